// File: rtl/branch_seq_ctrl.sv
// Multi-cycle branch sequencer: accepts one instruction over valid/ready and walks
// B/BL/CBZ/CBNZ/B.cond/BR through a small FSM, emitting a registered control word and K.
module branch_seq_ctrl #(
    parameter int unsigned DATA_WIDTH  = 64,
    parameter logic [4:0]  LINK_REG    = 5'd30,
    parameter bit          ENABLE_COND = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  inst_valid,
    input  logic [31:0]           I,
    input  logic [4:0]            status,
    output logic                  ready,
    output logic [32:0]           cw,
    output logic [DATA_WIDTH-1:0] K,
    output logic                  done,
    output logic                  illegal
);

    typedef enum logic [2:0] {
        StIdle, StEval, StLink, StTaken, StSeq, StBreg, StErr
    } state_e;

    localparam int AluEn   = 32;
    localparam int AluBs   = 31;
    localparam int AluFsLo = 26;
    localparam int RfSaLo  = 20;
    localparam int RfDaLo  = 10;
    localparam int RfW     = 9;
    localparam int PcEn    = 6;
    localparam int PcFsLo  = 4;
    localparam int PcIs    = 3;

    // alu_fs=11111, rf_sb=31, everything else (incl. next_state) zero
    localparam logic [32:0] CwSafe = 33'h0_7C0F_8000;

    state_e                state_q, state_d;
    logic [31:0]           inst_q, inst_d;
    logic [32:0]           cw_q, cw_d;
    logic [DATA_WIDTH-1:0] k_q, k_d;
    logic                  done_q, done_d;
    logic                  illegal_q, illegal_d;
    logic                  taken;

    function automatic state_e decode(input logic [10:0] op);
        if (op[10:5] == 6'b000101) begin
            return StTaken;
        end else if (op[10:5] == 6'b100101) begin
            return StLink;
        end else if (ENABLE_COND && (op[10:4] == 7'b1011010)) begin
            return StEval;
        end else if (ENABLE_COND && (op[10:3] == 8'b01010100)) begin
            return StEval;
        end else if (op == 11'b11010110000) begin
            return StBreg;
        end
        return StErr;
    endfunction

    // f = {V, C, N, Z}
    function automatic logic cond_holds(input logic [3:0] cond, input logic [3:0] f);
        logic r;
        case (cond[3:1])
            3'b000:  r = f[0];
            3'b001:  r = f[2];
            3'b010:  r = f[1];
            3'b011:  r = f[3];
            3'b100:  r = f[2] & ~f[0];
            3'b101:  r = (f[1] == f[3]);
            3'b110:  r = ~f[0] & (f[1] == f[3]);
            default: r = 1'b1;
        endcase
        if (cond[0] && (cond[3:1] != 3'b111)) begin
            r = ~r;
        end
        return r;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] off26(input logic [25:0] imm);
        logic [DATA_WIDTH+27:0] w;
        w = {{DATA_WIDTH{imm[25]}}, imm, 2'b00};
        return w[DATA_WIDTH-1:0];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] off19(input logic [18:0] imm);
        logic [DATA_WIDTH+20:0] w;
        w = {{DATA_WIDTH{imm[18]}}, imm, 2'b00};
        return w[DATA_WIDTH-1:0];
    endfunction

    always_comb begin
        if (inst_q[31:24] == 8'hB4) begin
            taken = status[0];
        end else if (inst_q[31:24] == 8'hB5) begin
            taken = ~status[0];
        end else begin
            taken = cond_holds(inst_q[3:0], status[4:1]);
        end
    end

    always_comb begin
        state_d = state_q;
        inst_d  = inst_q;
        case (state_q)
            StIdle: begin
                if (inst_valid) begin
                    inst_d  = I;
                    state_d = decode(I[31:21]);
                end
            end
            StEval:  state_d = taken ? StTaken : StSeq;
            StLink:  state_d = StTaken;
            default: state_d = StIdle;
        endcase
    end

    // Outputs are computed from the next state so they register together with it.
    always_comb begin
        cw_d      = CwSafe;
        k_d       = '0;
        done_d    = 1'b0;
        illegal_d = 1'b0;
        case (state_d)
            StEval: begin
                if (inst_d[31:25] == 7'b1011010) begin
                    cw_d[RfSaLo +: 5]  = inst_d[4:0];
                    cw_d[AluBs]        = 1'b1;
                    cw_d[AluFsLo +: 5] = 5'b00100;
                end
            end
            StLink: begin
                cw_d[PcEn]        = 1'b1;
                cw_d[PcFsLo +: 2] = 2'b00;
                cw_d[RfDaLo +: 5] = LINK_REG;
                cw_d[RfW]         = 1'b1;
            end
            StTaken: begin
                cw_d[PcEn]        = 1'b1;
                cw_d[PcFsLo +: 2] = 2'b10;
                cw_d[PcIs]        = 1'b0;
                done_d            = 1'b1;
                if ((inst_d[31:26] == 6'b000101) || (inst_d[31:26] == 6'b100101)) begin
                    k_d = off26(inst_d[25:0]);
                end else if ((inst_d[31:25] == 7'b1011010) || (inst_d[31:24] == 8'h54)) begin
                    k_d = off19(inst_d[23:5]);
                end
            end
            StSeq: begin
                cw_d[PcEn]        = 1'b1;
                cw_d[PcFsLo +: 2] = 2'b01;
                done_d            = 1'b1;
            end
            StBreg: begin
                cw_d[RfSaLo +: 5]  = inst_d[9:5];
                cw_d[AluEn]        = 1'b1;
                cw_d[AluBs]        = 1'b1;
                cw_d[AluFsLo +: 5] = 5'b00100;
                cw_d[PcEn]         = 1'b1;
                cw_d[PcFsLo +: 2]  = 2'b11;
                cw_d[PcIs]         = 1'b1;
                done_d             = 1'b1;
            end
            StErr: begin
                cw_d[PcEn]        = 1'b1;
                cw_d[PcFsLo +: 2] = 2'b01;
                illegal_d         = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            inst_q    <= '0;
            cw_q      <= CwSafe;
            k_q       <= '0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            inst_q    <= inst_d;
            cw_q      <= cw_d;
            k_q       <= k_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
        end
    end

    assign ready   = (state_q == StIdle);
    assign cw      = cw_q;
    assign K       = k_q;
    assign done    = done_q;
    assign illegal = illegal_q;

endmodule

// File: doc/branch_seq_ctrl.md
Name: branch_seq_ctrl

Overview:
Multi-cycle branch sequencer for the control unit; the successor to the single-state unconditional-branch decoder. Accepts one fetched instruction via a valid/ready handshake and steps through an internal state machine. Per state, it emits the 33-bit control word and the constant K for B, BL, CBZ, CBNZ, B.cond and BR. Decodes a plausible B/BL/CBZ/CBNZ/B.cond/BR subset and flags everything else as illegal.

Parameters:
DATA_WIDTH, 64, width of K and of the datapath.
LINK_REG, 30, register-file address written by BL.
ENABLE_COND, 1, 1 = decode CBZ/CBNZ/B.cond; 0 = treat them as illegal.

Ports:
clock  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
inst_valid  input  1  I is valid for acceptance.
I  input  32  instruction word.
status  input  5  {V,C,N,Z} registered flags in [4:1]; [0] = live ALU-output zero.
ready  output  1  high only in IDLE; acceptance = inst_valid & ready.
cw  output  33  {alu_en, alu_bs, alu_fs[4:0], rf_b_en, rf_sa[4:0], rf_sb[4:0], rf_da[4:0], rf_w, ram_en, ram_w, pc_en, pc_fs[1:0], pc_is, status_ld, next_state[1:0]}.
K  output  DATA_WIDTH  constant or offset driven into the datapath.
done  output  1  one-cycle pulse in the final state of a branch.
illegal  output  1  one-cycle pulse when the accepted opcode is not decoded.

Behaviour:
Reset (async): state=IDLE, latched instruction=0, done=0, illegal=0, K=0; cw=SAFE; ready=1 once reset deasserts.
SAFE cw:
- alu_fs=11111, rf_sb=31, rf_sa=0, rf_da=0, next_state=00; all other fields 0.
- pc_fs codes: 00 hold, 01 PC+4, 10 PC+K, 11 PC<=databus. pc_is: 0 = K, 1 = databus.
Accept edge latches I. States: IDLE, EVAL, LINK, TAKEN, SEQ, BREG, ERR.
Decode of the latched I (first match):
- I[31:26]=000101 B -> TAKEN.
- I[31:26]=100101 BL -> LINK.
- I[31:24]=10110100 CBZ or 10110101 CBNZ -> EVAL.
- I[31:24]=01010100 B.cond -> EVAL.
- I[31:21]=11010110000 BR -> BREG.
- Anything else -> ERR.
K offsets:
- B/BL: sign-extend(I[25:0])<<2 to DATA_WIDTH.
- CBZ/CBNZ/B.cond: sign-extend(I[23:5])<<2.
- Otherwise 0.
- Sign extension fills all DATA_WIDTH bits; the top bits shifted out are discarded.
EVAL (CBZ/CBNZ):
- Output: rf_sa=I[4:0], alu_bs=1, alu_fs=00100 (A OR K), K=0, pc_en=0.
- status[0] is sampled at the end of the cycle. Taken if CBZ&z or CBNZ&~z -> TAKEN, else -> SEQ.
EVAL (B.cond):
- Output: SAFE cw.
- cond=I[3:0] is evaluated against status[4:1] using the standard EQ..LE table; AL (1110) and NV (1111) are always taken.
LINK:
- Output: pc_en=1, pc_fs=00, rf_da=LINK_REG, rf_w=1; writes PC+4 via the PC databus output.
- -> TAKEN next cycle.
TAKEN:
- Output: pc_en=1, pc_fs=10, pc_is=0, K=offset, done=1.
- -> IDLE.
SEQ:
- Output: pc_en=1, pc_fs=01, done=1.
- -> IDLE.
BREG:
- Output: rf_sa=I[9:5], rf_b_en=0, alu_en=1, alu_bs=1, alu_fs=00100, K=0, pc_en=1, pc_fs=11, pc_is=1, done=1.
- ALU drives Rn onto the databus.
- -> IDLE.
ERR:
- Output: SAFE cw plus pc_en=1, pc_fs=01 (skip the instruction), illegal=1, done=0.
- -> IDLE.
Timing and invariants:
- Latency from the accept edge to the done cycle: B 1, BR 1, BL 2, CBZ/CBNZ/B.cond 2, illegal 1.
- status_ld=0 and ram_en=ram_w=0 in every state.
- cw, K, done and illegal are Moore outputs of the registered state and the latched I.
- inst_valid and I are ignored while ready=0. No new accept occurs on the done cycle; ready returns the cycle after done.
- Reset asserted mid-branch: immediately SAFE, no PC update, no done.
- ENABLE_COND=0: CBZ/CBNZ/B.cond go to ERR.

Test Plan:
1. B with imm26=0x3FFFFFF (−1): accept -> next cycle cw pc_fs=10, pc_is=0, K=0xFFFF_FFFF_FFFF_FFFC, done=1; ready=1 the following cycle.
2. BL with imm26=4: cycle 1 rf_da=30, rf_w=1, pc_fs=00; cycle 2 pc_fs=10, K=16, done=1.
3. CBZ X5, imm19=2, status[0]=1 in EVAL: EVAL has rf_sa=5, alu_fs=00100; then TAKEN with K=8. Repeat with status[0]=0 -> SEQ pc_fs=01.
4. B.GE (cond=1010): N=1,V=1 -> TAKEN; N=1,V=0 -> SEQ. Repeat with cond=1111 -> TAKEN regardless of flags.
5. BR X7 (0xD61F00E0): single cycle, rf_sa=7, alu_en=1, pc_fs=11, pc_is=1, done=1.
6. Opcode 0x8B000000 -> ERR pulse illegal=1, pc_fs=01. Separately: assert reset during LINK -> outputs SAFE within the same cycle, state=IDLE, no done.
